vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, system clocks per pixel (2 gives 25 MHz pixel rate from 50 MHz clk); legal values are 1 to 16.
REQ-002 SHALL have parameters H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48; pixel counts of each horizontal region.
REQ-003 SHALL have parameters V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33; line counts of each vertical region.
REQ-004 SHALL have parameter SYNC_ACT, default 0, the active level of hsync and vsync.
REQ-005 SHALL have port clk, input, 1, system clock; the only clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port hcount, output, 10, current pixel column, 0..H_TOT-1, where H_TOT = 800.
REQ-008 SHALL have port vcount, output, 10, current line, 0..V_TOT-1, where V_TOT = 525.
REQ-009 SHALL have port hsync, output, 1, horizontal sync to the monitor.
REQ-010 SHALL have port vsync, output, 1, vertical sync to the monitor and the frame-update strobe for the ball and paddle logic.
REQ-011 SHALL have port video_on, output, 1, high when the pixel is visible (hcount < H_VIS and vcount < V_VIS).
REQ-012 SHALL have port pix_tick, output, 1, one-clk pulse marking each pixel advance.
REQ-013 SHALL have port frame_start, output, 1, one-clk pulse when the counters wrap to (0,0).
REQ-014 SHALL have port frame_count, output, 16, number of frames completed since reset.

Function
REQ-015 The divider counter SHALL run 0..CLK_DIV-1 and wrap; pix_tick SHALL be high in the clk cycle after the divider reaches CLK_DIV-1, and with CLK_DIV=1 pix_tick SHALL be high every cycle.
REQ-016 hcount SHALL increment only on cycles with pix_tick high; at H_TOT-1 it SHALL wrap to 0 on the next pix_tick.
REQ-017 vcount SHALL increment only when hcount wraps; at V_TOT-1 it SHALL wrap to 0 together with hcount.
REQ-018 All outputs SHALL be registered, and hsync, vsync and video_on SHALL be valid in the same clk cycle as the hcount/vcount values they decode (zero relative latency).
REQ-019 hsync SHALL be at SYNC_ACT exactly for hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], which is 656..751 with defaults, and at the opposite level otherwise.
REQ-020 vsync SHALL be at SYNC_ACT exactly for vcount in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], which is 490..491 with defaults, for all hcount; the active edge therefore occurs when (hcount,vcount) becomes (0,490).
REQ-021 frame_start SHALL pulse for one clk in the cycle in which (hcount,vcount) transitions from (799,524) to (0,0), coincident with pix_tick.
REQ-022 frame_count SHALL increment by 1 in the same cycle frame_start is high, and SHALL wrap from 65535 to 0.
REQ-023 Counter arithmetic SHALL be unsigned, and hcount/vcount SHALL never present values at or above H_TOT/V_TOT.
REQ-024 Pixel-region timing SHALL be: 800 pixels per line, 525 lines per frame, 420000 pixel ticks per frame, and 840000 clk cycles per frame at CLK_DIV=2.

Reset
REQ-025 While reset is high, hcount=0, vcount=0, the divider counter=0, frame_count=0, pix_tick=0 and frame_start=0.
REQ-026 While reset is high, hsync=!SYNC_ACT, vsync=!SYNC_ACT and video_on=1, consistent with position (0,0).
REQ-027 No frame_start SHALL be issued on reset release; the first frame_start SHALL occur at the first (799,524)->(0,0) wrap.
REQ-028 Reset asserted mid-frame or mid-divide SHALL return all state to REQ-025/026 values on the next clk edge, with no partial pulses afterwards.
REQ-029 The first pix_tick after reset release SHALL occur CLK_DIV clk cycles after release.

Verification
REQ-030 Free run from reset at CLK_DIV=2 -> pix_tick period is 2 clk; hcount reaches 799 then 0; vcount increments by 1 at that wrap.
REQ-031 Line decode -> hsync low for exactly 96 consecutive pix_ticks starting at hcount=656; video_on low from hcount=640 through 799.
REQ-032 Full frame -> vsync low for exactly 1600 pix_ticks starting at (0,490); frame_start pulses once per 840000 clk; frame_count=1 after the first frame.
REQ-033 Reset asserted at (hcount,vcount)=(400,300) -> next cycle shows (0,0), frame_count=0, hsync=1, vsync=1; the next frame_start arrives 840000 clk after release.
REQ-034 frame_count preloaded via force to 65535, then one frame wrap -> frame_count=0 and frame_start high for exactly 1 clk.
REQ-035 CLK_DIV=1 build -> pix_tick is constant 1 after the first cycle; 420000 clk cycles per frame; sync windows unchanged in pixel units.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel divider, h/v counters, sync and blanking decode.
// Latency: every output is registered; syncs and video_on line up with the hcount/vcount they decode.
// Backpressure: none; free-running counters, and downstream logic samples on pix_tick.
//
// Ports:
//   clk, reset             system clock and synchronous active-high reset
//   hcount, vcount         current pixel column and line
//   hsync, vsync           monitor syncs at SYNC_ACT inside their windows
//   video_on               high while (hcount, vcount) lies in the visible area
//   pix_tick               one-clk pulse on each pixel advance
//   frame_start            one-clk pulse when the raster wraps to (0,0)
//   frame_count            frames completed since reset, modulo 2^16
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_nxt;
  logic             h_wrap;
  logic             frame_wrap;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;

  // Next raster position is computed here so the decodes below can be
  // registered from it and land in the same cycle as the counters.
  always_comb begin
    tick_nxt   = (div_cnt == DIV_MAX);
    h_wrap     = tick_nxt && (hcount == H_MAX);
    frame_wrap = h_wrap && (vcount == V_MAX);
    h_nxt      = hcount;
    v_nxt      = vcount;
    if (tick_nxt) begin
      h_nxt = h_wrap ? 10'd0 : hcount + 10'd1;
    end
    if (h_wrap) begin
      v_nxt = (vcount == V_MAX) ? 10'd0 : vcount + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hsync       <= !SYNC_ACT;
      vsync       <= !SYNC_ACT;
      video_on    <= 1'b1;
    end else begin
      div_cnt     <= tick_nxt ? '0 : div_cnt + DIV_W'(1);
      pix_tick    <= tick_nxt;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
      hsync    <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? SYNC_ACT : !SYNC_ACT;
      vsync    <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? SYNC_ACT : !SYNC_ACT;
      video_on <= (h_nxt < H_VIS_W) && (v_nxt < V_VIS_W);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: one full-size instance for reset and line
// decode, and two shrunken rasters (8 x 7, CLK_DIV 2 and 1) for frame-level
// behaviour so whole frames fit in a short run.
module tb_vga_timing;

  logic clk;
  int   checks;
  int   errors;

  logic        rst_a, rst_b, rst_c;
  logic [9:0]  hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic        hs_a, vs_a, vo_a, pt_a, fs_a;
  logic        hs_b, vs_b, vo_b, pt_b, fs_b;
  logic        hs_c, vs_c, vo_c, pt_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_timing dut_a (
    .clk(clk), .reset(rst_a), .hcount(hc_a), .vcount(vc_a), .hsync(hs_a),
    .vsync(vs_a), .video_on(vo_a), .pix_tick(pt_a), .frame_start(fs_a),
    .frame_count(fc_a)
  );

  // 8 pixels per line (hsync at 5..6), 7 lines per frame (vsync at 4..5).
  vga_timing #(
    .CLK_DIV(2), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .hcount(hc_b), .vcount(vc_b), .hsync(hs_b),
    .vsync(vs_b), .video_on(vo_b), .pix_tick(pt_b), .frame_start(fs_b),
    .frame_count(fc_b)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b0)
  ) dut_c (
    .clk(clk), .reset(rst_c), .hcount(hc_c), .vcount(vc_c), .hsync(hs_c),
    .vsync(vs_c), .video_on(vo_c), .pix_tick(pt_c), .frame_start(fs_c),
    .frame_count(fc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1;
    repeat (3) step;
    checks++; if (hc_a !== 10'd0) begin errors++; $display("FAIL rst_hcount got %0d want 0", hc_a); end
    checks++; if (vc_a !== 10'd0) begin errors++; $display("FAIL rst_vcount got %0d want 0", vc_a); end
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b want 1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b want 1", vs_a); end
    checks++; if (vo_a !== 1'b1) begin errors++; $display("FAIL rst_video_on got %b want 1", vo_a); end
    checks++; if (pt_a !== 1'b0) begin errors++; $display("FAIL rst_pix_tick got %b want 0", pt_a); end
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b want 0", fs_a); end
    checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL rst_frame_count got %0d want 0", fc_a); end
    rst_a = 1'b0;
    step;
    checks++; if (pt_a !== 1'b0 || hc_a !== 10'd0) begin errors++; $display("FAIL rel_cycle1 got pt=%b h=%0d want pt=0 h=0", pt_a, hc_a); end
    step;
    checks++; if (pt_a !== 1'b1 || hc_a !== 10'd1) begin errors++; $display("FAIL rel_first_tick got pt=%b h=%0d want pt=1 h=1", pt_a, hc_a); end
  endtask

  // Runs the rest of line 0 of the full-size raster up to the first wrap.
  task automatic test_line_decode;
    int gap = 0, gap_err = 0, dec_err = 0, fs_seen = 0;
    int hs_low = 0, hs_first = -1, vo_low = 0, vo_first = -1;
    int prev_hc = 1, wrap_prev = -1, wrap_vc = -1;
    bit done = 1'b0;
    bit exp_hs, exp_vo;
    for (int n = 0; n < 2000 && !done; n++) begin
      step;
      gap++;
      if (fs_a) fs_seen++;
      if (pt_a) begin
        if (gap != 2) gap_err++;
        gap = 0;
        if (hc_a == 10'd0) begin
          done = 1'b1;
          wrap_prev = prev_hc;
          wrap_vc = int'(vc_a);
        end else begin
          exp_hs = !(hc_a >= 10'd656 && hc_a <= 10'd751);
          exp_vo = (hc_a < 10'd640);
          if (hs_a !== exp_hs || vo_a !== exp_vo || vs_a !== 1'b1) dec_err++;
          if (!hs_a) begin hs_low++; if (hs_first < 0) hs_first = int'(hc_a); end
          if (!vo_a) begin vo_low++; if (vo_first < 0) vo_first = int'(hc_a); end
        end
        prev_hc = int'(hc_a);
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL line_wrap_timeout got none want wrap within 2000 clk"); end
    checks++; if (wrap_prev != 799 || wrap_vc != 1) begin errors++; $display("FAIL line_wrap got prev_h=%0d v=%0d want 799 1", wrap_prev, wrap_vc); end
    checks++; if (gap_err != 0) begin errors++; $display("FAIL tick_period got %0d bad gaps want 0", gap_err); end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_low); end
    checks++; if (hs_first != 656) begin errors++; $display("FAIL hsync_start got %0d want 656", hs_first); end
    checks++; if (vo_low != 160) begin errors++; $display("FAIL blank_width got %0d want 160", vo_low); end
    checks++; if (vo_first != 640) begin errors++; $display("FAIL blank_start got %0d want 640", vo_first); end
    checks++; if (dec_err != 0) begin errors++; $display("FAIL line_decode got %0d errs want 0", dec_err); end
    checks++; if (fs_seen != 0) begin errors++; $display("FAIL early_frame_start got %0d want 0", fs_seen); end
  endtask

  task automatic test_frame;
    int f1 = -1, f2 = -1, vs_low = 0, vs_h = -1, vs_v = -1;
    int range_err = 0, width_err = 0, f1_h = -1, f1_v = -1;
    logic f1_pt = 1'b0, prev_fs = 1'b0;
    logic [15:0] f1_fc = 16'hdead, f2_fc = 16'hdead;
    rst_b = 1'b1;
    repeat (2) step;
    rst_b = 1'b0;
    for (int n = 1; n <= 300 && f2 < 0; n++) begin
      step;
      if (hc_b >= 10'd8 || vc_b >= 10'd7) range_err++;
      if (fs_b && prev_fs) width_err++;
      prev_fs = fs_b;
      if (f1 < 0 && pt_b && !vs_b) begin
        vs_low++;
        if (vs_h < 0) begin vs_h = int'(hc_b); vs_v = int'(vc_b); end
      end
      if (fs_b) begin
        if (f1 < 0) begin
          f1 = n; f1_h = int'(hc_b); f1_v = int'(vc_b); f1_pt = pt_b; f1_fc = fc_b;
        end else begin
          f2 = n; f2_fc = fc_b;
        end
      end
    end
    checks++; if (f1 != 112) begin errors++; $display("FAIL first_frame_start got %0d want 112", f1); end
    checks++; if (f2 - f1 != 112) begin errors++; $display("FAIL frame_period got %0d want 112", f2 - f1); end
    checks++; if (f1_h != 0 || f1_v != 0 || f1_pt !== 1'b1) begin errors++; $display("FAIL frame_start_pos got h=%0d v=%0d pt=%b want 0 0 1", f1_h, f1_v, f1_pt); end
    checks++; if (f1_fc !== 16'd1) begin errors++; $display("FAIL frame_count_1 got %0d want 1", f1_fc); end
    checks++; if (f2_fc !== 16'd2) begin errors++; $display("FAIL frame_count_2 got %0d want 2", f2_fc); end
    checks++; if (vs_low != 16) begin errors++; $display("FAIL vsync_width got %0d want 16", vs_low); end
    checks++; if (vs_h != 0 || vs_v != 4) begin errors++; $display("FAIL vsync_start got h=%0d v=%0d want 0 4", vs_h, vs_v); end
    checks++; if (range_err != 0) begin errors++; $display("FAIL counter_range got %0d want 0", range_err); end
    checks++; if (width_err != 0) begin errors++; $display("FAIL frame_start_width got %0d want 0", width_err); end
  endtask

  task automatic test_midframe_reset;
    bit found = 1'b0;
    int fs_at = -1, pt_first = -1;
    for (int n = 0; n < 300 && !found; n++) begin
      step;
      if (hc_b == 10'd5 && vc_b == 10'd4) found = 1'b1;
    end
    checks++; if (!found || hs_b !== 1'b0 || vs_b !== 1'b0) begin errors++; $display("FAIL pre_reset_syncs got found=%b hs=%b vs=%b want 1 0 0", found, hs_b, vs_b); end
    rst_b = 1'b1;
    step;
    checks++; if (hc_b !== 10'd0 || vc_b !== 10'd0) begin errors++; $display("FAIL mid_reset_pos got h=%0d v=%0d want 0 0", hc_b, vc_b); end
    checks++; if (fc_b !== 16'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", fc_b); end
    checks++; if (hs_b !== 1'b1 || vs_b !== 1'b1 || vo_b !== 1'b1) begin errors++; $display("FAIL mid_reset_decode got hs=%b vs=%b vo=%b want 1 1 1", hs_b, vs_b, vo_b); end
    checks++; if (pt_b !== 1'b0 || fs_b !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got pt=%b fs=%b want 0 0", pt_b, fs_b); end
    rst_b = 1'b0;
    for (int n = 1; n <= 300 && fs_at < 0; n++) begin
      step;
      if (pt_b && pt_first < 0) pt_first = n;
      if (fs_b) fs_at = n;
    end
    checks++; if (pt_first != 2) begin errors++; $display("FAIL mid_reset_first_tick got %0d want 2", pt_first); end
    checks++; if (fs_at != 112) begin errors++; $display("FAIL mid_reset_frame_start got %0d want 112", fs_at); end
  endtask

  task automatic test_count_wrap;
    int fs_at = -1;
    logic [15:0] fc_at = 16'hdead;
    repeat (3) step;
    force dut_b.frame_count = 16'hffff;
    step;
    release dut_b.frame_count;
    step;
    checks++; if (fc_b !== 16'hffff) begin errors++; $display("FAIL preload got %0d want 65535", fc_b); end
    for (int n = 1; n <= 300 && fs_at < 0; n++) begin
      step;
      if (fs_b) begin fs_at = n; fc_at = fc_b; end
    end
    checks++; if (fs_at < 0 || fc_at !== 16'd0) begin errors++; $display("FAIL count_wrap got fs_at=%0d fc=%0d want fc 0", fs_at, fc_at); end
    step;
    checks++; if (fs_b !== 1'b0 || fc_b !== 16'd0) begin errors++; $display("FAIL wrap_pulse_width got fs=%b fc=%0d want 0 0", fs_b, fc_b); end
  endtask

  task automatic test_clk_div1;
    int fs_at = -1, pt_gaps = 0, hs_low = 0, hs_first = -1, vs_low = 0;
    rst_c = 1'b1;
    repeat (2) step;
    rst_c = 1'b0;
    step;
    checks++; if (pt_c !== 1'b1 || hc_c !== 10'd1) begin errors++; $display("FAIL div1_first_tick got pt=%b h=%0d want 1 1", pt_c, hc_c); end
    for (int n = 2; n <= 200 && fs_at < 0; n++) begin
      step;
      if (!pt_c) pt_gaps++;
      if (!hs_c) begin hs_low++; if (hs_first < 0) hs_first = int'(hc_c); end
      if (!vs_c) vs_low++;
      if (fs_c) fs_at = n;
    end
    checks++; if (fs_at != 56) begin errors++; $display("FAIL div1_frame got %0d want 56", fs_at); end
    checks++; if (pt_gaps != 0) begin errors++; $display("FAIL div1_tick_const got %0d gaps want 0", pt_gaps); end
    checks++; if (hs_low != 14 || hs_first != 5) begin errors++; $display("FAIL div1_hsync got n=%0d first=%0d want 14 5", hs_low, hs_first); end
    checks++; if (vs_low != 16) begin errors++; $display("FAIL div1_vsync got %0d want 16", vs_low); end
    checks++; if (fc_c !== 16'd1) begin errors++; $display("FAIL div1_count got %0d want 1", fc_c); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    test_reset;
    test_line_decode;
    test_frame;
    test_midframe_reset;
    test_count_wrap;
    test_clk_div1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
